// File: rtl/control_sequencer.sv
// Multicycle control sequencer: owns the 4-bit state register consumed by the control
// decoder, and reports instruction boundaries, illegal opcodes, halt and retired count.
module control_sequencer #(
   parameter int unsigned COUNT_W = 16,
   parameter logic [5:0]  HALT_OP = 6'b111111
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic [5:0]         opcode,
   input  logic               memReady,
   output logic [3:0]         state,
   output logic               instrDone,
   output logic               illegalOp,
   output logic               halted,
   output logic [COUNT_W-1:0] instrCount
);

   // Encoding is shared with the control decoder and must not change.
   typedef enum logic [3:0] {
      INSTRUCTION_FETCH    = 4'd0,
      REGISTER_FETCH       = 4'd1,
      ALU_R3               = 4'd2,
      ALU_RI3              = 4'd3,
      ALU_WB               = 4'd4,
      BRANCH3              = 4'd5,
      MEM_REF3             = 4'd6,
      LOAD4                = 4'd7,
      STORE4               = 4'd8,
      LOAD5                = 4'd9,
      JUMP3                = 4'd10,
      IMMEDIATE_INJECTION2 = 4'd11,
      HALT                 = 4'd12,
      IDLE                 = 4'd13
   } state_t;

   state_t             state_q;
   state_t             state_d;
   state_t             resume_state;
   logic               done_d;
   logic               done_q;
   logic               illegal_d;
   logic               illegal_q;
   logic               halted_q;
   logic [COUNT_W-1:0] count_q;

   // Where a completed instruction goes: straight into the next fetch, or park in IDLE.
   always_comb begin
      if (run) begin
         resume_state = INSTRUCTION_FETCH;
      end else begin
         resume_state = IDLE;
      end
   end

   // Next-state and completion decode.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = INSTRUCTION_FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         INSTRUCTION_FETCH: state_d = REGISTER_FETCH;
         REGISTER_FETCH: begin
            if (opcode == HALT_OP) begin
               state_d = HALT;
               done_d  = 1'b1;
            end else begin
               case (opcode[5:4])
                  2'b00:   state_d = ALU_R3;
                  2'b01:   state_d = ALU_RI3;
                  2'b10:   state_d = IMMEDIATE_INJECTION2;
                  default: begin
                     case (opcode[3:0])
                        4'b0000: state_d = MEM_REF3;
                        4'b0001: state_d = MEM_REF3;
                        4'b0010: state_d = BRANCH3;
                        4'b0011: state_d = JUMP3;
                        default: begin
                           state_d   = resume_state;
                           done_d    = 1'b1;
                           illegal_d = 1'b1;
                        end
                     endcase
                  end
               endcase
            end
         end
         ALU_R3:  state_d = ALU_WB;
         ALU_RI3: state_d = ALU_WB;
         ALU_WB, BRANCH3, JUMP3, IMMEDIATE_INJECTION2, LOAD5: begin
            state_d = resume_state;
            done_d  = 1'b1;
         end
         // IR stays stable for the whole instruction, so opcode[0] is re-read here.
         MEM_REF3: begin
            if (opcode[0]) begin
               state_d = STORE4;
            end else begin
               state_d = LOAD4;
            end
         end
         LOAD4: begin
            if (memReady) begin
               state_d = LOAD5;
            end else begin
               state_d = LOAD4;
            end
         end
         STORE4: begin
            if (memReady) begin
               state_d = resume_state;
               done_d  = 1'b1;
            end else begin
               state_d = STORE4;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // State and status registers; status pulses line up with the state they lead into.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
         count_q   <= {COUNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         halted_q  <= (state_d == HALT);
         if (done_d) begin
            count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
         end else begin
            count_q <= count_q;
         end
      end
   end

   assign state      = state_q;
   assign instrDone  = done_q;
   assign illegalOp  = illegal_q;
   assign halted     = halted_q;
   assign instrCount = count_q;

endmodule
